gradient_window: RTL and testbench

- Sits directly downstream of the downsample stage and consumes its pixel stream over a valid/ready handshake.
- Buffers two image lines and forms a 3x3 neighbourhood per accepted pixel.
- Emits signed central-difference gradients gx and gy for every interior pixel of each frame, with backpressure.
- Its output feeds the magnitude/orientation binning stage.

---
 rtl/gradient_window_pkg.sv | 15 +
 rtl/gradient_window_line_buffer.sv | 24 ++
 rtl/gradient_window.sv | 110 +++++++++++
 tb/tb_gradient_window.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gradient_window_pkg.sv
// Shared geometry and pixel-width defaults for the downsample -> gradient -> binning chain.
package gradient_window_pkg;

  localparam int IMG_WIDTH_DEF   = 64;
  localparam int IMG_HEIGHT_DEF  = 128;
  localparam int PIXEL_WIDTH_DEF = 8;

  // One extra bit holds the signed difference of two unsigned pixels.
  function automatic int grad_width(input int pixel_width);
    return pixel_width + 1;
  endfunction

  localparam int GRAD_WIDTH = grad_width(PIXEL_WIDTH_DEF);

endpackage

// File: rtl/gradient_window_line_buffer.sv
// Single-port line store with read-before-write: rdata shows the old word while it is overwritten.
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Write the new word on enable; the combinational read above still returns the previous one.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gradient_window.sv
// Two-line buffered 3x3 neighbourhood producing central-difference gx/gy for interior pixels.
module gradient_window
  import gradient_window_pkg::*;
#(
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH:0]   out_gx,
  output logic [PIXEL_WIDTH:0]   out_gy,
  output logic                   out_last
);

  localparam int GW = grad_width(PIXEL_WIDTH);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]          col_r;
  logic [RW-1:0]          row_r;
  logic [PIXEL_WIDTH-1:0] lb0_rd_s;
  logic [PIXEL_WIDTH-1:0] lb1_rd_s;
  logic [PIXEL_WIDTH-1:0] w1_top_r;
  logic [PIXEL_WIDTH-1:0] w1_mid_r;
  logic [PIXEL_WIDTH-1:0] w1_bot_r;
  logic [PIXEL_WIDTH-1:0] w2_mid_r;
  logic                   accept_s;
  logic                   emit_s;
  logic                   last_s;
  logic [GW-1:0]          gx_s;
  logic [GW-1:0]          gy_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;
  assign emit_s   = (row_r >= RW'(2)) && (col_r >= CW'(2));
  assign last_s   = (row_r == ROW_LAST) && (col_r == COL_LAST);

  // The incoming column (lb1, lb0, pixel) is column c; w1 holds column c-1, w2_mid the middle of c-2.
  assign gx_s = {1'b0, lb0_rd_s} - {1'b0, w2_mid_r};
  assign gy_s = {1'b0, w1_bot_r} - {1'b0, w1_top_r};

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb0 (
    .clk   (clk),
    .en    (accept_s),
    .addr  (col_r),
    .wdata (in_pixel),
    .rdata (lb0_rd_s)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clk   (clk),
    .en    (accept_s),
    .addr  (col_r),
    .wdata (lb0_rd_s),
    .rdata (lb1_rd_s)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= CW'(0);
      row_r <= RW'(0);
    end else if (accept_s) begin
      if (col_r == COL_LAST) begin
        col_r <= CW'(0);
        row_r <= (row_r == ROW_LAST) ? RW'(0) : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Shift the two previous columns of the neighbourhood; stale row-end columns are never emitted.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      w1_top_r <= lb1_rd_s;
      w1_mid_r <= lb0_rd_s;
      w1_bot_r <= in_pixel;
      w2_mid_r <= w1_mid_r;
    end
  end

  // Output register: reloads on the same edge an output is taken, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gx    <= '0;
      out_gy    <= '0;
      out_last  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= emit_s;
      if (emit_s) begin
        out_gx   <= gx_s;
        out_gy   <= gy_s;
        out_last <= last_s;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gradient_window.sv
// Scoreboard bench for gradient_window on an 8x6 frame.
module tb_gradient_window;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_gx;
  logic [8:0] out_gy;
  logic       out_last;

  typedef struct packed {
    logic [8:0] gx;
    logic [8:0] gy;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img [H][W];
  int         checks = 0;
  int         errors = 0;
  int         mr = 0, mc = 0;
  int         pops = 0, lasts = 0, cyc = 0, first_pop = -1, last_pop = -1;
  int         stall_left = 0;
  bit         stall_arm = 1'b0;
  bit         acc = 1'b0;
  bit         const_chk = 1'b0;
  logic [8:0] const_gx, const_gy, snap_gx, snap_gy;

  always #5 clk = ~clk;

  gradient_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gx    (out_gx),
    .out_gy    (out_gy),
    .out_last  (out_last)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fill(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0:       img[r][c] = 8'(4 * c);
          1:       img[r][c] = 8'(10 * r);
          2:       img[r][c] = 8'(255 - 16 * c);
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endfunction

  // One clock: check at the falling edge, model accepted pixels, then move past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (stall_left > 0) begin
      if (stall_left == 5) begin
        snap_gx = out_gx;
        snap_gy = out_gy;
      end else begin
        check("stall_gx", 32'(out_gx), 32'(snap_gx));
        check("stall_gy", 32'(out_gy), 32'(snap_gy));
      end
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      stall_left--;
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed gx %0h gy %0h, expected no output", out_gx, out_gy);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("gx", 32'(out_gx), 32'(e.gx));
        check("gy", 32'(out_gy), 32'(e.gy));
        check("last", 32'(out_last), 32'(e.last));
      end
      if (const_chk) begin
        check("gx_const", 32'(out_gx), 32'(const_gx));
        check("gy_const", 32'(out_gy), 32'(const_gy));
      end
      pops++;
      if (out_last) lasts++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (stall_arm) begin
        stall_arm  = 1'b0;
        stall_left = 5;
      end
    end
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      if (mr >= 2 && mc >= 2) begin
        e.gx   = {1'b0, img[mr-1][mc]} - {1'b0, img[mr-1][mc-2]};
        e.gy   = {1'b0, img[mr][mc-1]} - {1'b0, img[mr-2][mc-1]};
        e.last = (mr == H - 1) && (mc == W - 1);
        sb.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int vprob, input int rprob, input int rst_at);
    int t;
    for (int i = 0; i < W * H; i++) begin
      if (i == rst_at) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        mr = 0; mc = 0; pops = 0; lasts = 0;
        check("post_reset_valid", 32'(out_valid), 32'd0);
        rst_at = -1;
        i = 0;
      end
      in_pixel = img[i / W][i % W];
      t = 0;
      do begin
        in_valid  = ($urandom_range(0, 99) < vprob);
        out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rprob);
        step();
        t++;
      end while (!acc && t < 2000);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_and_count(input int exp_outs, input int exp_lasts);
    int t;
    t = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      step();
      t++;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
    check("out_count", 32'(pops), 32'(exp_outs));
    check("last_count", 32'(lasts), 32'(exp_lasts));
    pops = 0;
    lasts = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = 8'd0;
    const_gx = 9'd0; const_gy = 9'd0; snap_gx = 9'd0; snap_gy = 9'd0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_gx", 32'(out_gx), 32'd0);
    check("reset_gy", 32'(out_gy), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Horizontal ramp at full rate: gx=8, one output per cycle inside each row.
    fill(0); const_chk = 1'b1; const_gx = 9'd8; const_gy = 9'd0; first_pop = -1;
    send_frame(100, 100, -1);
    drain_and_count(24, 1);
    check("throughput_span", 32'(last_pop - first_pop), 32'd29);

    // Vertical ramp: gy=20.
    fill(1); const_gx = 9'd0; const_gy = 9'd20;
    send_frame(100, 100, -1);
    drain_and_count(24, 1);

    // Falling ramp: negative gx in nine bits.
    fill(2); const_gx = 9'h1E0; const_gy = 9'd0;
    send_frame(100, 100, -1);
    drain_and_count(24, 1);

    // Five-cycle stall right after the first output.
    fill(0); const_gx = 9'd8; const_gy = 9'd0; stall_arm = 1'b1;
    send_frame(100, 100, -1);
    drain_and_count(24, 1);

    // Random data with random handshakes on both sides.
    fill(3); const_chk = 1'b0;
    send_frame(50, 50, -1);
    drain_and_count(24, 1);

    // Reset at row 3 col 4, then a complete frame.
    fill(3);
    send_frame(80, 80, 3 * W + 4);
    drain_and_count(24, 1);

    // Two back-to-back frames with different content.
    fill(3);
    send_frame(100, 100, -1);
    fill(3);
    send_frame(100, 100, -1);
    drain_and_count(48, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
